controle_arrolhamento: RTL

Corking-station controller that sequences the cork dispenser (`dispensadorrolhas`) for the bottling line. It keeps a local hopper of up to 15 corks and refills it from the dispenser in batches. When a bottle is present it drives the cork press for a fixed number of cycles, loads new stock into the dispenser on operator request, and raises an alarm when a bottle waits with no corks available.

---
 rtl/controle_arrolhamento_pkg.sv | 30 +++
 rtl/controle_arrolhamento_if.sv | 44 ++++
 rtl/controle_arrolhamento_temporizador.sv | 40 ++++
 rtl/controle_arrolhamento.sv | 112 +++++++++++
 4 files changed

// File: rtl/controle_arrolhamento_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pkg_vinho
// Description : Shared definitions for the corking-station controller:
//               FSM state codes, counter/hopper widths, hopper capacity and
//               a saturating-increment helper for the bottle counter.
// Revision    : 1.0 - initial release
// ============================================================================
package pkg_vinho;

    localparam int W_CONT    = 8;   // width of counts exchanged with the dispenser
    localparam int W_FUNIL   = 5;   // width of the local hopper count
    localparam int FUNIL_MAX = 15;  // hopper capacity in corks

    typedef enum logic [2:0] {
        OCIOSO   = 3'd0,
        DISPENSA = 3'd1,
        ARROLHA  = 3'd2,
        LIBERA   = 3'd3,
        CARGA    = 3'd4,
        ALARME   = 3'd5
    } estado_t;

    // Increment that sticks at all-ones instead of wrapping.
    function automatic logic [W_CONT-1:0] incr_sat(input logic [W_CONT-1:0] v);
        return (v == {W_CONT{1'b1}}) ? v : v + 1'b1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/controle_arrolhamento_if.sv
`default_nettype none
// ============================================================================
// Module      : controle_arrolhamento_if
// Description : Bundle between the corking controller and its environment
//               (bottle sensor, operator panel, cork dispenser, press).
//               master : the controller (drives commands and status)
//               slave  : the environment (drives sensors and dispenser data)
// Revision    : 1.0 - initial release
// ============================================================================
interface controle_arrolhamento_if;
    import pkg_vinho::*;

    // environment -> controller
    logic                garrafa;      // bottle present under the press
    logic                repor;        // operator refill request
    logic [W_CONT-1:0]   qtd_repor;    // corks to load into the dispenser
    logic [W_CONT-1:0]   estoque;      // dispenser stock (monitor only)
    logic                vazio;        // dispenser empty flag
    logic [W_CONT-1:0]   dispensado;   // corks released this cycle

    // controller -> environment
    logic                enable_disp;  // dispense command
    logic                load_disp;    // load command
    logic [W_CONT-1:0]   dados_disp;   // load value
    logic                arrolhar;     // cork-press drive
    logic [W_FUNIL-1:0]  funil;        // local hopper count
    logic [W_CONT-1:0]   garrafas_ok;  // bottles corked since reset
    logic                alarme;       // bottle waiting with no corks anywhere
    logic [2:0]          estado;       // FSM state code (debug)

    modport master (
        input  garrafa, repor, qtd_repor, estoque, vazio, dispensado,
        output enable_disp, load_disp, dados_disp, arrolhar, funil,
               garrafas_ok, alarme, estado
    );

    modport slave (
        output garrafa, repor, qtd_repor, estoque, vazio, dispensado,
        input  enable_disp, load_disp, dados_disp, arrolhar, funil,
               garrafas_ok, alarme, estado
    );

endinterface
`default_nettype wire

// File: rtl/controle_arrolhamento_temporizador.sv
`default_nettype none
// ============================================================================
// Module      : temporizador_prensa
// Description : Press-duration timer. 4-bit down-counter loaded with
//               PRESS_CYCLES-1 when a press starts; o_fim is high while the
//               count is 0, marking the last press cycle.
// Ports       : clk, rst      - clock, synchronous active-high reset
//               i_carga       - load PRESS_CYCLES-1 (press about to start)
//               i_habilita    - count down (press in progress)
//               o_fim         - current press cycle is the last one
// Revision    : 1.0 - initial release
// ============================================================================
module temporizador_prensa #(
    parameter int PRESS_CYCLES = 4
) (
    input  wire logic clk,
    input  wire logic rst,
    input  wire logic i_carga,
    input  wire logic i_habilita,
    output logic      o_fim
);

    localparam logic [3:0] c_VALOR_CARGA = 4'(PRESS_CYCLES - 1);

    logic [3:0] r_cont;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cont <= 4'd0;
        end else if (i_carga) begin
            r_cont <= c_VALOR_CARGA;
        end else if (i_habilita && (r_cont != 4'd0)) begin
            r_cont <= r_cont - 4'd1;
        end
    end

    assign o_fim = (r_cont == 4'd0);

endmodule
`default_nettype wire

// File: rtl/controle_arrolhamento.sv
`default_nettype none
// ============================================================================
// Module      : controle_arrolhamento
// Description : Corking-station controller. Keeps a local hopper of up to
//               15 corks refilled from the dispenser, drives the cork press
//               for PRESS_CYCLES cycles per bottle, loads dispenser stock on
//               operator request and raises an alarm when a bottle waits with
//               hopper and dispenser both empty.
// Ports       : clock, reset  - system clock, synchronous active-high reset
//               bus (master)  - sensors/dispenser in, commands/status out
// Revision    : 1.0 - initial release
// ============================================================================
module controle_arrolhamento
    import pkg_vinho::*;
#(
    parameter int PRESS_CYCLES = 4
) (
    input  wire logic               clock,
    input  wire logic               reset,
    controle_arrolhamento_if.master bus
);

    estado_t             r_estado;
    estado_t             w_prox;
    logic                r_enable_disp;
    logic                r_load_disp;
    logic                r_arrolhar;
    logic                r_alarme;
    logic [W_FUNIL-1:0]  r_funil;
    logic [W_CONT-1:0]   r_garrafas_ok;
    logic                w_funil_vazio;
    logic                w_fim;
    logic                w_inicia_prensa;
    logic                w_unused;

    assign w_funil_vazio = (r_funil == '0);

    // Next-state decision; the OCIOSO branch order is the priority order.
    always_comb begin
        w_prox = r_estado;
        case (r_estado)
            OCIOSO: begin
                if (bus.repor)                                    w_prox = CARGA;
                else if (w_funil_vazio && !bus.vazio)             w_prox = DISPENSA;
                else if (bus.garrafa && !w_funil_vazio)           w_prox = ARROLHA;
                else if (bus.garrafa && w_funil_vazio && bus.vazio) w_prox = ALARME;
                else                                              w_prox = OCIOSO;
            end
            DISPENSA: w_prox = OCIOSO;
            ARROLHA:  w_prox = w_fim ? LIBERA : ARROLHA;
            LIBERA:   w_prox = bus.garrafa ? LIBERA : OCIOSO;
            CARGA:    w_prox = OCIOSO;
            ALARME:   w_prox = bus.repor ? CARGA : ALARME;
            default:  w_prox = OCIOSO;
        endcase
    end

    // ARROLHA is only ever entered from OCIOSO, so this is the entry edge.
    assign w_inicia_prensa = (r_estado == OCIOSO) && (w_prox == ARROLHA);

    temporizador_prensa #(
        .PRESS_CYCLES (PRESS_CYCLES)
    ) u_temporizador (
        .clk        (clock),
        .rst        (reset),
        .i_carga    (w_inicia_prensa),
        .i_habilita (r_estado == ARROLHA),
        .o_fim      (w_fim)
    );

    // State, Moore outputs (registered from the next state so they line up
    // with the state register), hopper and bottle counter.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_estado      <= OCIOSO;
            r_enable_disp <= 1'b0;
            r_load_disp   <= 1'b0;
            r_arrolhar    <= 1'b0;
            r_alarme      <= 1'b0;
            r_funil       <= '0;
            r_garrafas_ok <= '0;
        end else begin
            r_estado      <= w_prox;
            r_enable_disp <= (w_prox == DISPENSA);
            r_load_disp   <= (w_prox == CARGA);
            r_arrolhar    <= (w_prox == ARROLHA);
            r_alarme      <= (w_prox == ALARME);

            // Dispenser batches never exceed 15, so the low bits are the count.
            if (r_estado == DISPENSA) begin
                r_funil <= bus.dispensado[W_FUNIL-1:0];
            end else if ((r_estado == ARROLHA) && w_fim) begin
                r_funil       <= r_funil - 1'b1;
                r_garrafas_ok <= incr_sat(r_garrafas_ok);
            end
        end
    end

    // Stock level is informational and the batch upper bits are always zero.
    assign w_unused = ^{bus.estoque, bus.dispensado[W_CONT-1:W_FUNIL]};

    assign bus.enable_disp = r_enable_disp;
    assign bus.load_disp   = r_load_disp;
    assign bus.dados_disp  = r_load_disp ? bus.qtd_repor : '0;
    assign bus.arrolhar    = r_arrolhar;
    assign bus.alarme      = r_alarme;
    assign bus.funil       = r_funil;
    assign bus.garrafas_ok = r_garrafas_ok;
    assign bus.estado      = r_estado;

endmodule
`default_nettype wire
